// File: rtl/frame_buf_reader.sv
// Frame buffer read engine: issues word requests for one frame,
// buffers returns in a small FIFO and emits pixels with sof/eol/eof.
module frame_buf_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int H_PIXELS   = 4,
  parameter int V_LINES    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_l,
  input  logic                  buf_rdy,
  output logic                  rd_en_l,
  input  logic                  rd_data_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic                  busy,
  output logic                  overflow
);

  localparam int TOTAL = H_PIXELS * V_LINES;
  localparam int RW = $clog2(TOTAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [RW-1:0] req_cnt;
  logic [CW-1:0] outst;
  logic [CW-1:0] fcount;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [CW:0]   inflight;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic issue;
  logic last_req;
  logic ret_ok;
  logic push;
  logic pop;
  logic full;
  logic start_go;
  logic col_last;
  logic row_last;

  // FIFO slots already filled plus words still in flight bound requests
  assign inflight = {1'b0, fcount} + {1'b0, outst};
  assign full     = fcount == CW'(FIFO_DEPTH);

  assign issue = (state == FETCH) && buf_rdy &&
                 (req_cnt < RW'(TOTAL)) &&
                 (inflight < (CW+1)'(FIFO_DEPTH));

  assign rd_en_l  = !issue;
  assign last_req = issue && (req_cnt == RW'(TOTAL - 1));
  assign start_go = (state == IDLE) && !start_l;

  assign ret_ok = rd_data_valid && (outst != '0);
  assign push   = ret_ok && !full;

  assign pix_valid = fcount != '0;
  assign pop       = pix_valid && pix_ready;
  assign pix_data  = mem[rd_ptr];

  assign col_last = col == XW'(H_PIXELS - 1);
  assign row_last = row == YW'(V_LINES - 1);

  assign pix_sof = pix_valid && (col == '0) && (row == '0);
  assign pix_eol = pix_valid && col_last;
  assign pix_eof = pix_eol && row_last;

  assign busy = state != IDLE;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!start_l) state_nxt = FETCH;
      FETCH:   if (last_req) state_nxt = DRAIN;
      DRAIN:   if (pop && pix_eof) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req_cnt  <= '0;
      outst    <= '0;
      col      <= '0;
      row      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_go) begin
        req_cnt <= '0;
        outst   <= '0;
        col     <= '0;
        row     <= '0;
      end else begin
        if (issue) req_cnt <= req_cnt + 1'b1;
        case ({issue, ret_ok})
          2'b10:   outst <= outst + 1'b1;
          2'b01:   outst <= outst - 1'b1;
          default: outst <= outst;
        endcase
        if (pop) begin
          if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
      // unsolicited or unbufferable return words are dropped
      if (rd_data_valid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: fcount <= fcount;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

endmodule

// File: tb/tb_frame_buf_reader.sv
// Scoreboard bench for frame_buf_reader: directed frames against a
// one-cycle-latency memory model, pixels checked by a monitor.
module tb_frame_buf_reader;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_l;
  logic          buf_rdy;
  logic          rd_en_l;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;
  logic          busy;
  logic          overflow;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
    logic          eof;
  } pix_t;

  pix_t exp_q[$];
  int   checks  = 0;
  int   passed  = 0;
  int   reqs    = 0;
  int   pix_cnt = 0;
  int   mem_idx = 0;
  bit   inject  = 1'b0;
  bit   chk_busy = 1'b0;

  frame_buf_reader #(
    .DATA_WIDTH(DW),
    .H_PIXELS(4),
    .V_LINES(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_l(start_l),
    .buf_rdy(buf_rdy),
    .rd_en_l(rd_en_l),
    .rd_data_valid(rd_data_valid),
    .rd_data(rd_data),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_sof(pix_sof),
    .pix_eol(pix_eol),
    .pix_eof(pix_eof),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(string name);
    chk(name, {rd_en_l, pix_valid, pix_sof, pix_eol,
               pix_eof, busy, overflow}, 7'b1000000);
  endtask

  task automatic start_frame();
    pix_t p;
    mem_idx = 0;
    reqs    = 0;
    pix_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      p.d   = DW'(i);
      p.sof = (i == 0);
      p.eol = (i % 4 == 3);
      p.eof = (i == 7);
      exp_q.push_back(p);
    end
    start_l = 1'b0;
    tick();
    start_l = 1'b1;
  endtask

  task automatic wait_done(string name);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!busy && exp_q.size() == 0) break;
    end
    chk({name, "_done"}, {busy, exp_q.size() == 0}, 2'b01);
  endtask

  // memory model: returns mem_idx one cycle after each request
  initial begin
    bit req;
    rd_data_valid = 1'b0;
    rd_data       = '0;
    forever begin
      @(negedge clk);
      req = (rd_en_l === 1'b0);
      @(posedge clk);
      #1;
      if (req && reset === 1'b1) begin
        rd_data_valid = 1'b1;
        rd_data       = DW'(mem_idx);
        mem_idx++;
      end else if (inject) begin
        rd_data_valid = 1'b1;
        rd_data       = 32'hdead_beef;
        inject        = 1'b0;
      end else begin
        rd_data_valid = 1'b0;
      end
    end
  end

  // monitor: pops the scoreboard on every pixel transfer
  initial begin
    pix_t a;
    pix_t e;
    forever begin
      @(negedge clk);
      if (chk_busy) begin
        chk("busy_after_eof", busy, 0);
        chk_busy = 1'b0;
      end
      if (reset === 1'b1 && pix_valid === 1'b1 && pix_ready === 1'b1) begin
        a.d   = pix_data;
        a.sof = pix_sof;
        a.eol = pix_eol;
        a.eof = pix_eof;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pixel: got %0h expected none", a);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", a, e);
          if (e.eof) chk_busy = 1'b1;
        end
        pix_cnt++;
      end
      if (rd_en_l === 1'b0) reqs++;
    end
  end

  initial begin
    reset     = 1'b0;
    start_l   = 1'b1;
    buf_rdy   = 1'b1;
    pix_ready = 1'b1;
    #1;
    check_idle("reset_state");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    start_frame();
    wait_done("basic");
    chk("basic_reqs", reqs, 8);

    pix_ready = 1'b0;
    start_frame();
    repeat (20) tick();
    chk("stall_reqs", reqs, 4);
    chk("stall_rd_en_l", rd_en_l, 1);
    chk("stall_head", {pix_valid, pix_data}, {1'b1, 32'h0});
    pix_ready = 1'b1;
    wait_done("stall");
    chk("stall_total_reqs", reqs, 8);

    start_frame();
    repeat (2) tick();
    buf_rdy = 1'b0;
    repeat (3) begin
      #1;
      chk("bufrdy_rd_en_l", rd_en_l, 1);
      tick();
    end
    buf_rdy = 1'b1;
    wait_done("bufrdy");
    chk("bufrdy_reqs", reqs, 8);

    start_frame();
    start_l = 1'b0;
    repeat (3) tick();
    start_l = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      #1;
      if (reqs == 8) break;
    end
    chk("restart_in_drain", busy, 1);
    start_l = 1'b0;
    tick();
    start_l = 1'b1;
    wait_done("no_restart");
    chk("no_restart_reqs", reqs, 8);
    repeat (3) tick();
    chk("no_restart_idle", busy, 0);

    start_frame();
    for (int i = 0; i < 100; i++) begin
      if (pix_cnt >= 5) break;
      tick();
    end
    chk("mid_frame_pixels", pix_cnt, 5);
    #1;
    reset = 1'b0;
    #1;
    check_idle("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_held");
    reset = 1'b1;
    repeat (2) tick();
    chk("no_stale", {pix_valid, busy}, 2'b00);
    start_frame();
    wait_done("after_reset");
    chk("after_reset_reqs", reqs, 8);

    inject = 1'b1;
    repeat (2) tick();
    chk("overflow_set", overflow, 1);
    chk("overflow_no_pixel", pix_valid, 0);
    repeat (5) tick();
    chk("overflow_sticky", {overflow, pix_valid, busy}, 3'b100);
    reset = 1'b0;
    #1;
    check_idle("overflow_cleared");
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/frame_buf_reader.md
FRAME_BUF_READER -- requirements
Module: frame_buf_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the pixel word width.
REQ-002 Parameter H_PIXELS, default 4, SHALL set the number of pixels per line.
REQ-003 Parameter V_LINES, default 2, SHALL set the number of lines per frame.
REQ-004 Parameter FIFO_DEPTH, default 4 (power of two, >=2), SHALL set the return-data FIFO depth.
REQ-005 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 start_l  in  1  SHALL be the active-low frame-start request.
REQ-008 buf_rdy  in  1  SHALL be high when the frame buffer holds readable data.
REQ-009 rd_en_l  out  1  SHALL be the active-low read request to the frame buffer; one word is requested per rising edge on which it is low.
REQ-010 rd_data_valid  in  1  SHALL be high for one cycle per returned word.
REQ-011 rd_data  in  DATA_WIDTH  SHALL be the returned word, sampled when rd_data_valid is high.
REQ-012 pix_data  out  DATA_WIDTH  SHALL be the FIFO head word.
REQ-013 pix_valid / pix_ready  out / in  1  SHALL form the pixel handshake; a pixel transfers on an edge where both are high.
REQ-014 pix_sof, pix_eol, pix_eof  out  1  SHALL mark first pixel of frame, last pixel of line, and last pixel of frame; they are qualified by pix_valid.
REQ-015 busy  out  1  SHALL be high whenever state is not IDLE.
REQ-016 overflow  out  1  SHALL be a sticky error flag.

Function
REQ-017 State machine SHALL have states IDLE, FETCH, DRAIN.
REQ-018 IDLE -> FETCH on an edge with start_l low; start_l SHALL be ignored in FETCH and DRAIN.
REQ-019 On IDLE -> FETCH, request counter, outstanding counter, column and row counters SHALL clear to 0.
REQ-020 FETCH: rd_en_l SHALL be low in a cycle only if buf_rdy is high, requests issued < H_PIXELS*V_LINES, and FIFO count + outstanding < FIFO_DEPTH, each evaluated in that cycle; rd_en_l SHALL be high otherwise.
REQ-021 FETCH -> DRAIN on the edge that issues the final (H_PIXELS*V_LINES-th) request.
REQ-022 Outstanding SHALL increment on an edge with rd_en_l low, decrement on an edge with rd_data_valid high, and remain unchanged when both occur.
REQ-023 Each rd_data_valid word SHALL be pushed into the FIFO on that edge; pix_valid SHALL be high in the cycle after the push (one-cycle latency).
REQ-024 pix_valid SHALL equal (FIFO count != 0); pix_data SHALL hold its value while pix_valid is high and pix_ready low.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve order; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Column counter SHALL increment per transferred pixel, wrapping to 0 after H_PIXELS-1 and incrementing row; pix_sof = (col==0 && row==0), pix_eol = (col==H_PIXELS-1), pix_eof = pix_eol && (row==V_LINES-1).
REQ-027 DRAIN -> IDLE on the edge transferring the pix_eof pixel; no further requests SHALL issue in DRAIN.
REQ-028 A push when FIFO is full, or rd_data_valid with outstanding==0, SHALL set overflow and discard the word; overflow SHALL clear only on reset.
REQ-029 buf_rdy low SHALL only stall requests; in-flight returns and output transfers SHALL continue.
REQ-030 pix_ready low SHALL never cause data loss; requests throttle through REQ-020.

Reset
REQ-031 reset low SHALL immediately force: state IDLE, rd_en_l=1, pix_valid=0, pix_sof=pix_eol=pix_eof=0, busy=0, overflow=0, all counters and FIFO pointers 0, regardless of clk.
REQ-032 reset asserted mid-frame SHALL abandon the frame; after release the block SHALL await a new start_l and SHALL not emit stale FIFO data.

Verification
REQ-033 Defaults, buf_rdy=1, pix_ready=1, memory returns data 1 cycle after each request with values 0..7 -> exactly 8 requests, pixels 0..7 in order, sof on 0, eol on 3 and 7, eof on 7, busy falls the edge after pixel 7.
REQ-034 pix_ready held 0, return latency 1 -> exactly 4 requests issue, rd_en_l then stays high, pix_data=0 held; releasing pix_ready resumes, all 8 pixels delivered intact.
REQ-035 buf_rdy toggled 0 for 3 cycles mid-FETCH -> rd_en_l high during those cycles, no lost or duplicated pixels, sequence 0..7.
REQ-036 rd_data_valid pulse while idle (outstanding 0) -> overflow=1 and stays 1 until reset; pix_valid stays 0.
REQ-037 reset pulsed low after 5 pixels transferred -> all outputs at REQ-031 values asynchronously; subsequent start_l yields full 8-pixel frame starting with sof.
REQ-038 start_l low during FETCH and DRAIN -> no restart, counters unaffected, frame completes normally.
